// File: rtl/gfx_pixel_reader.sv
// Pixel fetch unit: turns (x,y) into a render-target address and returns
// the pixel, caching the most recently fetched 32-byte memory line.
module gfx_pixel_reader #(
  parameter int point_width = 16,
  parameter int MDW         = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            target_base_i,
  input  logic [point_width-1:0] target_size_x_i,
  input  logic [point_width-1:0] target_size_y_i,
  input  logic [5:0]             bpp_i,
  input  logic [point_width-1:0] pixel_x_i,
  input  logic [point_width-1:0] pixel_y_i,
  input  logic                   read_i,
  input  logic                   invalidate_i,
  output logic                   ack_o,
  output logic [31:0]            color_o,
  output logic                   oob_o,
  output logic                   busy_o,
  output logic                   read_o,
  output logic [31:0]            read_addr_o,
  output logic [31:0]            read_sel_o,
  input  logic [MDW-1:0]         read_dat_i,
  input  logic                   ack_i
);

  typedef enum logic [2:0] {
    IDLE, CALC, CHECK, FETCH, DONE
  } state_t;

  state_t state_q, state_d;

  logic [point_width-1:0] x_q, x_d;
  logic [point_width-1:0] y_q, y_d;
  logic [31:0]            addr_q, addr_d;
  logic                   oob_q, oob_d;
  logic                   valid_q, valid_d;
  logic [31:0]            tag_q, tag_d;
  logic [31:0]            color_q, color_d;
  logic [MDW-1:0]         line_q, line_d;

  logic [31:0]    bytes_pp;
  logic [31:0]    offset;
  logic [31:0]    word_addr;
  logic [7:0]     bitoff;
  logic [MDW-1:0] src;
  logic [31:0]    sh32;
  logic [31:0]    pix;
  logic           base_unused;

  // Low base bits are ignored: the target is line aligned.
  assign base_unused = ^target_base_i[4:0];

  assign word_addr = {addr_q[31:5], 5'b0};
  assign bitoff    = {addr_q[4:0], 3'b0};

  always_comb begin
    bytes_pp = 32'd4;
    case (bpp_i)
      6'd8:    bytes_pp = 32'd1;
      6'd16:   bytes_pp = 32'd2;
      default: bytes_pp = 32'd4;
    endcase
  end

  assign offset = (32'(y_q) * 32'(target_size_x_i) + 32'(x_q)) * bytes_pp;

  // During a fill the pixel is taken straight from the bus data.
  always_comb begin
    src  = (state_q == FETCH) ? read_dat_i : line_q;
    sh32 = 32'(src >> bitoff);
    pix  = sh32;
    case (bpp_i)
      6'd8:    pix = {24'd0, sh32[7:0]};
      6'd16:   pix = {16'd0, sh32[15:0]};
      default: pix = sh32;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    oob_d   = oob_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    color_d = color_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (read_i) begin
          x_d     = pixel_x_i;
          y_d     = pixel_y_i;
          state_d = CALC;
        end
      end
      CALC: begin
        addr_d  = {target_base_i[31:5], 5'b0} + offset;
        oob_d   = (x_q >= target_size_x_i) ||
                  (y_q >= target_size_y_i);
        state_d = CHECK;
      end
      CHECK: begin
        if (oob_q) begin
          color_d = 32'd0;
          state_d = DONE;
        end else if (valid_q && tag_q == word_addr) begin
          color_d = pix;
          state_d = DONE;
        end else begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (ack_i) begin
          line_d  = read_dat_i;
          tag_d   = word_addr;
          valid_d = 1'b1;
          color_d = pix;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Invalidate wins over a coincident fill.
    if (invalidate_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      oob_q   <= 1'b0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      oob_q   <= oob_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      color_q <= color_d;
    end
  end

  always_ff @(posedge clk_i) begin
    line_q <= line_d;
  end

  assign ack_o       = (state_q == DONE);
  assign oob_o       = ack_o & oob_q;
  assign busy_o      = (state_q != IDLE);
  assign read_o      = (state_q == FETCH);
  assign read_addr_o = read_o ? word_addr : 32'd0;
  assign read_sel_o  = read_o ? 32'hFFFF_FFFF : 32'd0;
  assign color_o     = color_q;

endmodule

// File: tb/tb_gfx_pixel_reader.sv
// Bench for gfx_pixel_reader: byte-level memory model plus a one-line
// cache model predict address, colour, hit/miss and latency.
module tb_gfx_pixel_reader;
  localparam int PW  = 16;
  localparam int MDW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   base;
  logic [PW-1:0] sx, sy, px, py;
  logic [5:0]    bpp;
  logic          rd, inv, ack_i;
  logic          ack_o, oob_o, busy_o, read_o;
  logic [31:0]   color_o, raddr, rsel;
  logic [MDW-1:0] rdat;

  int checks = 0;
  int errors = 0;

  bit [7:0]    mem [int unsigned];
  bit          mvalid;
  int unsigned mtag;

  always #5 clk = ~clk;

  gfx_pixel_reader #(.point_width(PW), .MDW(MDW)) dut (
    .clk_i(clk), .rst_i(rst),
    .target_base_i(base),
    .target_size_x_i(sx), .target_size_y_i(sy),
    .bpp_i(bpp),
    .pixel_x_i(px), .pixel_y_i(py),
    .read_i(rd), .invalidate_i(inv),
    .ack_o(ack_o), .color_o(color_o), .oob_o(oob_o),
    .busy_o(busy_o), .read_o(read_o),
    .read_addr_o(raddr), .read_sel_o(rsel),
    .read_dat_i(rdat), .ack_i(ack_i)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit [7:0] mb(input int unsigned a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  task automatic garbage();
    for (int i = 0; i < MDW / 32; i++) rdat[32*i +: 32] = $urandom;
  endtask

  // One request; inv_k pulses invalidate in relative cycle inv_k (0 = none).
  task automatic do_read(input logic [PW-1:0] x, input logic [PW-1:0] y,
                         input int dly, input int inv_k);
    int unsigned bytes, off, bya, wa;
    bit          oob, hit, got;
    logic [31:0] col;
    longint      lin;
    int          k, rd_first, fill_k, ack_k;
    bytes = (bpp == 6'd8) ? 1 : (bpp == 6'd16) ? 2 : 4;
    oob   = (x >= sx) || (y >= sy);
    lin   = (longint'(y) * longint'(sx) + longint'(x)) * longint'(bytes);
    off   = lin[31:0];
    bya   = {base[31:5], 5'b0} + off;
    wa    = bya & ~32'h1f;
    hit   = !oob && mvalid && (mtag == wa);
    col   = 32'd0;
    if (!oob)
      for (int b = 0; b < bytes; b++)
        col |= 32'(mb(bya + b)) << (8 * b);

    @(negedge clk);
    px = x; py = y; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    k = 1; got = 0; rd_first = -1; fill_k = -1; ack_k = -1;
    chk("busy_calc", busy_o, 1);
    while (!got && k < 40) begin
      inv = (k == inv_k);
      if (read_o) begin
        if (rd_first < 0) rd_first = k;
        chk("read_addr", raddr, wa);
        chk("read_sel", rsel, 32'hFFFF_FFFF);
        if (k - rd_first == dly) begin
          ack_i = 1'b1;
          for (int b = 0; b < 32; b++) rdat[8*b +: 8] = mb(wa + b);
          fill_k = k;
        end
      end
      if (ack_o) begin
        got   = 1;
        ack_k = k;
        chk("color", color_o, col);
        chk("oob", oob_o, oob);
        chk("read_low_at_ack", read_o, 0);
      end
      @(posedge clk); #1;
      ack_i = 1'b0; inv = 1'b0; garbage();
      k++;
    end
    chk("ack_seen", got, 1);
    chk("first_read_cycle", rd_first, (hit || oob) ? -1 : 3);
    chk("ack_cycle", ack_k, (hit || oob) ? 3 : fill_k + 1);
    chk("ack_pulse", ack_o, 0);
    chk("color_hold", color_o, col);
    chk("busy_idle", busy_o, 0);

    if (!hit && !oob) begin
      mvalid = 1; mtag = wa;
      if (inv_k >= fill_k && inv_k <= ack_k) mvalid = 0;
    end else if (inv_k >= 1 && inv_k <= ack_k) begin
      mvalid = 0;
    end
  endtask

  task automatic inv_pulse(input bit scramble);
    @(negedge clk); inv = 1'b1;
    @(negedge clk); inv = 1'b0;
    mvalid = 0;
    if (scramble) mem.delete();
  endtask

  task automatic stray_ack();
    @(negedge clk); ack_i = 1'b1; garbage();
    repeat (2) @(negedge clk);
    ack_i = 1'b0;
  endtask

  task automatic reset_mid_fetch(input logic [PW-1:0] x,
                                 input logic [PW-1:0] y);
    @(negedge clk);
    px = x; py = y; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pre_read", read_o, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_read_o", read_o, 0);
    chk("rst_ack_o", ack_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_addr", raddr, 0);
    chk("rst_color", color_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_no_ack", ack_o, 0);
    end
    mvalid = 0;
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; inv = 1'b0; ack_i = 1'b0;
    base = '0; sx = '0; sy = '0; px = '0; py = '0; bpp = 6'd16;
    garbage();
    mvalid = 0; mtag = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", ack_o, 0);
    chk("reset_read", read_o, 0);
    chk("reset_oob", oob_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_addr", raddr, 0);
    chk("reset_sel", rsel, 0);
    chk("reset_color", color_o, 0);
    rst = 1'b0;

    base = 32'h1000; sx = 640; sy = 480; bpp = 6'd16;
    do_read(3, 0, 2, 0);
    do_read(5, 0, 0, 0);
    do_read(640, 0, 0, 0);
    do_read(0, 480, 0, 0);
    bpp = 6'd32;
    do_read(7, 1, 1, 0);
    bpp = 6'd16;
    do_read(3, 0, 0, 0);
    do_read(5, 0, 0, 0);
    stray_ack();
    do_read(5, 0, 0, 0);
    inv_pulse(1);
    do_read(5, 0, 1, 0);
    do_read(5, 0, 0, 2);
    do_read(5, 0, 1, 4);
    do_read(5, 0, 0, 0);
    bpp = 6'd8;
    do_read(33, 2, 0, 0);
    bpp = 6'd24;
    do_read(1, 0, 3, 0);
    inv_pulse(0);
    bpp = 6'd16;
    reset_mid_fetch(9, 3);
    do_read(9, 3, 0, 0);

    for (int it = 0; it < 80; it++) begin
      int r, d, ik;
      if (it % 8 == 0) begin
        base = $urandom;
        sx   = PW'($urandom_range(1, 64));
        sy   = PW'($urandom_range(1, 8));
      end
      r = $urandom_range(0, 5);
      bpp = (r == 0) ? 6'd8 : (r == 1) ? 6'd16 : (r == 2) ? 6'd32 :
            (r == 3) ? 6'd24 : (r == 4) ? 6'd0 : 6'd63;
      d  = $urandom_range(0, 3);
      r  = $urandom_range(0, 7);
      ik = (r == 0) ? 2 : (r == 1) ? 3 + d : 0;
      do_read(PW'($urandom_range(0, sx + 2)),
              PW'($urandom_range(0, sy + 1)), d, ik);
      r = $urandom_range(0, 15);
      if (r == 0) inv_pulse(1);
      if (r == 1) stray_ack();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gfx_pixel_reader.md
GFX_PIXEL_READER -- requirements
Module: gfx_pixel_reader

Interface
REQ-001 SHALL have parameter point_width, default 16, giving the coordinate width.
REQ-002 SHALL have parameter MDW, default 256, giving the memory data width in bits; 32-byte words.
REQ-003 SHALL have clk_i  in  1  single clock; every register updates on its rising edge.
REQ-004 SHALL have rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have target_base_i  in  32  byte address of the render target; bits [4:0] are treated as zero.
REQ-006 SHALL have target_size_x_i and target_size_y_i  in  point_width each  target width and height in pixels.
REQ-007 SHALL have bpp_i  in  6  bits per pixel; 8, 16 and 32 are supported, and any other value reads as 32.
REQ-008 SHALL have pixel_x_i and pixel_y_i  in  point_width each  pixel coordinates, sampled together with read_i.
REQ-009 SHALL have read_i  in  1  request strobe, honoured only in IDLE.
REQ-010 SHALL have invalidate_i  in  1  clears the line cache, because the renderer may have overwritten it.
REQ-011 SHALL have ack_o  out  1  one-cycle completion pulse.
REQ-012 SHALL have color_o  out  32  the zero-extended pixel, valid while ack_o is high and held afterwards.
REQ-013 SHALL have oob_o  out  1  out-of-bounds flag, qualified by ack_o.
REQ-014 SHALL have busy_o  out  1  high whenever the state is not IDLE.
REQ-015 SHALL have read_o  out  1  memory read request.
REQ-016 SHALL have read_addr_o  out  32  memory word address.
REQ-017 SHALL have read_sel_o  out  32  byte selects.
REQ-018 SHALL have read_dat_i  in  MDW  memory read data.
REQ-019 SHALL have ack_i  in  1  memory acknowledge.

Function
REQ-020 SHALL implement the states IDLE, CALC, CHECK, FETCH and DONE.
REQ-021 SHALL, in IDLE with read_i high, capture the coordinates and go to CALC; read_i in any other state is ignored.
REQ-022 SHALL, in CALC, register offset = (y*size_x + x) * (bpp/8), truncated to 32 bits, and register the byte address base + offset.
REQ-023 SHALL, in CALC, register oob = (x >= size_x) or (y >= size_y), using unsigned compares.
REQ-024 SHALL derive word address = byte address with [4:0] cleared, and bit offset = byte address[4:0] * 8.
REQ-025 SHALL, in CHECK, take the first applicable action:
- oob set: go to DONE with color 0 and oob_o high;
- line valid and tag equal to the word address: go to DONE (hit);
- otherwise: go to FETCH.
REQ-026 SHALL, in FETCH, hold read_o high, read_addr_o = word address and read_sel_o = 32'hFFFFFFFF, all stable until ack_i.
REQ-027 SHALL, on ack_i in FETCH, store read_dat_i as the line, set tag and valid, and go to DONE.
REQ-028 SHALL deassert read_o in the cycle after ack_i.
REQ-029 SHALL, in DONE, drive ack_o high for exactly one cycle with color_o = line[bitoff +: bpp], zero-extended, then go to IDLE.
REQ-030 SHALL meet these latencies, with read_i sampled in cycle N:
- hit or oob: ack_o in cycle N+3;
- miss: read_o first high in N+3; ack_i seen in cycle M gives ack_o in M+1.
REQ-031 SHALL clear valid on invalidate_i in any state.
REQ-032 SHALL, when invalidate_i and a FETCH fill coincide, leave valid clear while the current request still returns the fetched data.
REQ-033 SHALL ignore ack_i outside FETCH.
REQ-034 SHALL read the pixel from line data even when invalidate_i coincides with CHECK on a hit, because the CHECK decision is taken on valid before the clear.

Reset
REQ-035 SHALL, on rst_i, force state IDLE and clear valid.
REQ-036 SHALL, on rst_i, clear ack_o, read_o, oob_o and busy_o to 0, read_addr_o, read_sel_o and color_o to 0, and tag to 0.
REQ-037 SHALL abandon any in-flight fetch on rst_i, with read_o low from the next cycle and no ack_o issued.

Verification
REQ-038 SHALL cover a miss: base 0x1000, 640x480, bpp 16, read (3,0), then ack_i 2 cycles after read_o -> read_addr_o 0x1000, color_o = dat[63:48], ack_o one cycle after ack_i.
REQ-039 SHALL cover a hit: after REQ-038, read (5,0) -> no read_o, ack_o at N+3, color_o = dat[95:80].
REQ-040 SHALL cover out-of-bounds: read (640,0) -> oob_o=1, color_o=0, ack_o at N+3, no read_o.
REQ-041 SHALL cover a 32 bpp read: (7,1) -> read_addr_o 0x1A00, color_o = dat[255:224].
REQ-042 SHALL cover invalidation: invalidate_i pulse, then repeat read (5,0) -> miss with read_o asserted.
REQ-043 SHALL cover reset mid-fetch: rst_i during FETCH -> read_o=0 next cycle, no ack_o, and the next read of the same word misses.
